// File: rtl/m16_imit.sv
// M16 telemetry-stream imitator: free-running NRZ Orb bit stream built from
// frame/phrase markers, a phrase counter word and fixed data words.
module m16_imit #(
   parameter int unsigned BIT_DIV     = 16,
   parameter logic [11:0] DATA_WORD   = 12'h666,
   parameter logic [11:0] FRAME_MARK  = 12'hF12,
   parameter logic [11:0] PHRASE_MARK = 12'h0ED
) (
   input  logic clk100,
   input  logic clr,
   output logic Orb_serial
);

   localparam logic [15:0] DIV_LAST = 16'(BIT_DIV - 1);

   logic [15:0] div_cnt_q, div_cnt_d;
   logic [3:0]  bit_cnt_q, bit_cnt_d;
   logic [3:0]  word_cnt_q, word_cnt_d;
   logic [4:0]  phrase_cnt_q, phrase_cnt_d;
   logic        orb_q, orb_d;
   logic [11:0] word_cur;

   always_comb begin
      word_cur = DATA_WORD;
      if (word_cnt_q == 4'd0) begin
         word_cur = (phrase_cnt_q == 5'd0) ? FRAME_MARK : PHRASE_MARK;
      end else if (word_cnt_q == 4'd1) begin
         word_cur = {7'b0, phrase_cnt_q};
      end
   end

   always_comb begin
      div_cnt_d    = (div_cnt_q == DIV_LAST) ? 16'd0 : div_cnt_q + 16'd1;
      bit_cnt_d    = bit_cnt_q;
      word_cnt_d   = word_cnt_q;
      phrase_cnt_d = phrase_cnt_q;
      orb_d        = orb_q;
      if (div_cnt_q == 16'd0) begin
         orb_d = word_cur[bit_cnt_q];
         if (bit_cnt_q == 4'd0) begin
            bit_cnt_d  = 4'd11;
            // word (16) and phrase (32) counts are full powers of two, so they wrap naturally
            word_cnt_d = word_cnt_q + 4'd1;
            if (word_cnt_q == 4'd15) begin
               phrase_cnt_d = phrase_cnt_q + 5'd1;
            end
         end else begin
            bit_cnt_d = bit_cnt_q - 4'd1;
         end
      end
   end

   always_ff @(posedge clk100 or negedge clr) begin
      if (!clr) begin
         div_cnt_q    <= 16'd0;
         bit_cnt_q    <= 4'd11;
         word_cnt_q   <= 4'd0;
         phrase_cnt_q <= 5'd0;
         orb_q        <= 1'b0;
      end else begin
         div_cnt_q    <= div_cnt_d;
         bit_cnt_q    <= bit_cnt_d;
         word_cnt_q   <= word_cnt_d;
         phrase_cnt_q <= phrase_cnt_d;
         orb_q        <= orb_d;
      end
   end

   assign Orb_serial = orb_q;

endmodule

// File: tb/tb_m16_imit.sv
// Self-checking bench for m16_imit: two instances (BIT_DIV 16 and 4) checked
// cycle-by-cycle against a stream model, plus word-level vector table.
module tb_m16_imit;
   localparam int DIV_A = 16;
   localparam int DIV_B = 4;
   localparam int NRUN  = 12288 * DIV_B + 24 * DIV_B;

   logic clk100 = 1'b0;
   always #5 clk100 = ~clk100;

   logic clr_a, clr_b, orb_a, orb_b;

   m16_imit #(.BIT_DIV(DIV_A)) u_dut_a (.clk100(clk100), .clr(clr_a), .Orb_serial(orb_a));
   m16_imit #(.BIT_DIV(DIV_B)) u_dut_b (.clk100(clk100), .clr(clr_b), .Orb_serial(orb_b));

   typedef struct {
      string       name;
      int          sel;
      int          start;
      logic [11:0] exp;
   } vec_t;

   int   n_tests = 0;
   int   n_fail  = 0;
   logic exp_q_a[$];
   logic exp_q_b[$];
   bit   run_a = 1'b0, run_b = 1'b0;
   int   edge_a = 0, edge_b = 0;
   logic cap_a[4096];
   logic cap_b[12400];
   vec_t vecs[14];

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic model_bit(int k);
      int p, w, b;
      logic [11:0] wd;
      p = (k / 192) % 32;
      w = (k / 12) % 16;
      b = 11 - (k % 12);
      if (w == 0)      wd = (p == 0) ? 12'hF12 : 12'h0ED;
      else if (w == 1) wd = 12'(p);
      else             wd = 12'h666;
      return wd[b];
   endfunction

   function automatic logic [11:0] get_word(int sel, int start);
      logic [11:0] w;
      w = '0;
      for (int j = 0; j < 12; j++)
         w[11-j] = (sel == 0) ? cap_a[start+j] : cap_b[start+j];
      return w;
   endfunction

   always @(negedge clk100) begin
      if (run_a) exp_q_a.push_back(model_bit(edge_a / DIV_A));
      if (run_b) exp_q_b.push_back(model_bit(edge_b / DIV_B));
   end

   always @(posedge clk100) begin
      #1;
      if (run_a) begin
         if (exp_q_a.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL sb_a: no expected entry at edge %0d", edge_a);
         end else begin
            check("stream_a", 32'(orb_a), 32'(exp_q_a.pop_front()));
         end
         if (edge_a % DIV_A == DIV_A / 2 && edge_a / DIV_A < 4096) cap_a[edge_a / DIV_A] = orb_a;
         edge_a++;
      end
      if (run_b) begin
         if (exp_q_b.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL sb_b: no expected entry at edge %0d", edge_b);
         end else begin
            check("stream_b", 32'(orb_b), 32'(exp_q_b.pop_front()));
         end
         if (edge_b % DIV_B == DIV_B / 2 && edge_b / DIV_B < 12400) cap_b[edge_b / DIV_B] = orb_b;
         edge_b++;
      end
   end

   task automatic start_run();
      @(posedge clk100);
      #2;
      edge_a = 0; edge_b = 0;
      clr_a = 1'b1; clr_b = 1'b1;
      run_a = 1'b1; run_b = 1'b1;
   endtask

   initial begin
      int diffs;
      vecs[0]  = '{"a_frame_mark",  0, 0,    12'hF12};
      vecs[1]  = '{"a_phrase0_cnt", 0, 12,   12'h000};
      vecs[2]  = '{"a_data_w2",     0, 24,   12'h666};
      vecs[3]  = '{"a_data_w15",    0, 180,  12'h666};
      vecs[4]  = '{"a_phrase_mark", 0, 192,  12'h0ED};
      vecs[5]  = '{"a_phrase1_cnt", 0, 204,  12'h001};
      vecs[6]  = '{"a_p1_data",     0, 216,  12'h666};
      vecs[7]  = '{"b_frame_mark",  1, 0,    12'hF12};
      vecs[8]  = '{"b_p31_mark",    1, 5952, 12'h0ED};
      vecs[9]  = '{"b_p31_cnt",     1, 5964, 12'h01F};
      vecs[10] = '{"b_wrap_mark",   1, 6144, 12'hF12};
      vecs[11] = '{"b_wrap_cnt",    1, 6156, 12'h000};
      vecs[12] = '{"b_f1_p1_mark",  1, 6336, 12'h0ED};
      vecs[13] = '{"b_f1_p1_cnt",   1, 6348, 12'h001};

      clr_a = 1'b0; clr_b = 1'b0;
      repeat (30) begin
         @(posedge clk100); #1;
         check("reset_a", 32'(orb_a), 32'd0);
         check("reset_b", 32'(orb_b), 32'd0);
      end

      start_run();
      repeat (NRUN) @(posedge clk100);
      #2;
      run_a = 1'b0; run_b = 1'b0;

      for (int i = 0; i < 14; i++)
         check(vecs[i].name, 32'(get_word(vecs[i].sel, vecs[i].start)), 32'(vecs[i].exp));

      diffs = 0;
      for (int k = 0; k < 6144; k++)
         if (cap_b[k] !== cap_b[k + 6144]) diffs++;
      check("frame_repeat_diffs", 32'(diffs), 32'd0);

      clr_a = 1'b0; clr_b = 1'b0;
      repeat (3) @(posedge clk100);
      start_run();
      repeat (1000) @(posedge clk100);
      #2;
      run_a = 1'b0; run_b = 1'b0;
      check("pre_clr_a", 32'(orb_a), 32'(model_bit(999 / DIV_A)));
      check("pre_clr_b", 32'(orb_b), 32'(model_bit(999 / DIV_B)));
      clr_a = 1'b0; clr_b = 1'b0;
      #1;
      check("async_clr_a", 32'(orb_a), 32'd0);
      check("async_clr_b", 32'(orb_b), 32'd0);
      repeat (5) begin
         @(posedge clk100); #1;
         check("clr_hold_a", 32'(orb_a), 32'd0);
         check("clr_hold_b", 32'(orb_b), 32'd0);
      end

      start_run();
      repeat (13 * DIV_A) @(posedge clk100);
      #2;
      run_a = 1'b0; run_b = 1'b0;
      check("restart_a_mark", 32'(get_word(0, 0)), 32'h0F12);
      check("restart_b_mark", 32'(get_word(1, 0)), 32'h0F12);
      check("restart_b_cnt",  32'(get_word(1, 12)), 32'h0000);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
